// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type, default widths and packed-slice helper for the RAM port arbiter
package ram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, TURN} state_t;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int SLICE_BUS_W = 1024;
    function automatic logic [63:0] slice_of(logic [SLICE_BUS_W-1:0] bus, int idx, int w);
        logic [SLICE_BUS_W-1:0] sh;
        sh = bus >> (idx * w);
        return sh[63:0] & ((64'd1 << w) - 64'd1);
    endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder, first set bit at or above ptr with wrap-around
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // descending scan so the smallest offset from ptr is the one left standing
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx = IW'((int'(ptr) + i) % N);
                any = 1'b1;
            end
        end
        onehot = '0;
        if (any) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin, burst-bounded sharing of one cs/we/oe RAM port with bus turnaround
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ram_cs,
    output logic                      ram_we,
    output logic                      ram_oe,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, id_q, id_d, pick_idx;
    logic [NUM_REQ-1:0] own_oh_q, own_oh_d, pick_oh;
    logic [CW-1:0] cnt_q, cnt_d;
    logic last_dir_q, last_dir_d, issued_q, issued_d;
    logic cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [RD_LAT-1:0] pv_q, pv_d;
    logic [RD_LAT-1:0][IW-1:0] pid_q, pid_d;
    logic pick_any, own_req, own_we, dir_ok, at_max, others;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req(req), .ptr(rr_q), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
    );

    always_comb begin
        own_req    = req[owner_q];
        own_we     = req_we[owner_q];
        dir_ok     = !issued_q || (own_we == last_dir_q);
        at_max     = cnt_q == CW'(MAX_BURST);
        others     = |(req & ~own_oh_q);
        state_d    = state_q;
        owner_d    = owner_q;
        own_oh_d   = own_oh_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        last_dir_d = last_dir_q;
        issued_d   = issued_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        oe_d       = oe_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        gnt        = '0;
        case (state_q)
            IDLE: if (pick_any) begin
                state_d  = ACTIVE;
                owner_d  = pick_idx;
                own_oh_d = pick_oh;
                cnt_d    = '0;
                issued_d = 1'b0;
            end
            ACTIVE: if (!own_req || (at_max && others)) begin
                state_d = IDLE;
                rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end else if (!dir_ok) begin
                state_d = TURN;
                oe_d    = 1'b1;
            end else begin
                gnt[owner_q] = 1'b1;
                cs_d         = 1'b1;
                we_d         = own_we;
                oe_d         = !own_we;
                addr_d       = ADDR_W'(slice_of(SLICE_BUS_W'(req_addr), int'(owner_q), ADDR_W));
                wdata_d      = DATA_W'(slice_of(SLICE_BUS_W'(req_wdata), int'(owner_q), DATA_W));
                id_d         = owner_q;
                issued_d     = 1'b1;
                last_dir_d   = own_we;
                // a lone owner keeps streaming: the burst count restarts instead of releasing
                cnt_d        = at_max ? CW'(1) : cnt_q + 1'b1;
            end
            TURN: begin
                state_d    = ACTIVE;
                last_dir_d = !last_dir_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pv_d     = '0;
        pid_d    = '0;
        pv_d[0]  = cs_q && !we_q;
        pid_d[0] = id_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i]  = pv_q[i-1];
            pid_d[i] = pid_q[i-1];
        end
        rvalid = '0;
        if (pv_q[RD_LAT-1]) rvalid[pid_q[RD_LAT-1]] = 1'b1;
        rdata = pv_q[RD_LAT-1] ? ram_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            own_oh_q   <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            last_dir_q <= 1'b0;
            issued_q   <= 1'b0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            oe_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= '0;
            pv_q       <= '0;
            pid_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            own_oh_q   <= own_oh_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            last_dir_q <= last_dir_d;
            issued_q   <= issued_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            pv_q       <= pv_d;
            pid_q      <= pid_d;
        end
    end

    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_oe    = oe_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != IDLE) || (|pv_q);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a behavioural RAM, per-scenario tasks
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req, req_we, gnt, rvalid;
    logic [31:0] req_addr, req_wdata;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
    logic ram_cs, ram_we, ram_oe, busy;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // RAM: never-written locations read back as addr^A5, data valid one cycle after cs
    logic [7:0] mem [256];
    logic [255:0] written = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        ram_rdata <= (ram_cs && !ram_we) ? (written[ram_addr] ? mem[ram_addr] : ram_addr ^ 8'hA5) : 8'hEE;
    end

    typedef struct packed {logic we; logic [7:0] addr; logic [7:0] data;} beat_t;
    typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
    beat_t bq[4][$];
    exp_t sb[$];
    int g_id[$], g_cyc[$];
    int checks = 0, errors = 0;
    logic [7:0] shadow [256];
    logic [255:0] sh_wr = '0;
    logic [3:0] tr_gnt [512], tr_rv [512];
    logic [7:0] tr_rd [512];
    logic tr_cs [512], tr_we [512], tr_oe [512];

    function automatic logic [7:0] expect_rd(logic [7:0] a);
        return sh_wr[a] ? shadow[a] : a ^ 8'hA5;
    endfunction

    function automatic bit all_empty();
        return bq[0].size() == 0 && bq[1].size() == 0 && bq[2].size() == 0 && bq[3].size() == 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = bq[i].size() > 0;
            if (bq[i].size() > 0) begin
                req_we[i]            = bq[i][0].we;
                req_addr[i*8 +: 8]   = bq[i][0].addr;
                req_wdata[i*8 +: 8]  = bq[i][0].data;
            end
        end
    endtask

    task automatic sample(input int c);
        beat_t b;
        exp_t e;
        if (c < 512) begin
            tr_gnt[c] = gnt; tr_rv[c] = rvalid; tr_rd[c] = rdata;
            tr_cs[c] = ram_cs; tr_we[c] = ram_we; tr_oe[c] = ram_oe;
        end
        if (gnt != 4'h0) begin
            checks++;
            if ((gnt & (gnt - 4'd1)) != 4'h0) begin
                errors++; $display("FAIL gnt_onehot cycle %0d got %b", c, gnt);
            end
        end
        for (int i = 0; i < 4; i++) if (gnt[i]) begin
            checks++;
            if (!req[i] || bq[i].size() == 0) begin
                errors++; $display("FAIL gnt_without_req cycle %0d requester %0d", c, i);
            end else begin
                b = bq[i].pop_front();
                if (b.we) begin
                    shadow[b.addr] = b.data; sh_wr[b.addr] = 1'b1;
                end else sb.push_back(exp_t'{id: 2'(i), data: expect_rd(b.addr)});
            end
            g_id.push_back(i);
            g_cyc.push_back(c);
        end
        if (rvalid != 4'h0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++; $display("FAIL unexpected_rvalid cycle %0d got %b", c, rvalid);
            end else begin
                e = sb.pop_front();
                if (rvalid !== (4'b1 << e.id) || rdata !== e.data) begin
                    errors++;
                    $display("FAIL read_return cycle %0d got rvalid %b rdata %h expected %b %h", c, rvalid, rdata, 4'b1 << e.id, e.data);
                end
            end
        end
        if (ram_cs) begin
            checks++;
            if (ram_oe !== !ram_we) begin
                errors++; $display("FAIL bus_dir cycle %0d we %b oe %b", c, ram_we, ram_oe);
            end
        end
    endtask

    task automatic run(input int max_c, input int stop_gnts);
        bit done = 1'b0;
        g_id.delete();
        g_cyc.delete();
        for (int c = 0; c < max_c && !done; c++) begin
            drive();
            @(negedge clk);
            sample(c);
            done = (stop_gnts > 0) ? (g_id.size() >= stop_gnts) : (all_empty() && sb.size() == 0 && !busy);
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL run_timeout after %0d cycles got grants %0d", max_c, g_id.size());
        end
        if (stop_gnts == 0) begin
            checks++;
            if (sb.size() != 0) begin
                errors++; $display("FAIL missing_rvalid got %0d outstanding required 0", sb.size());
            end
        end
    endtask

    task automatic do_reset();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) bq[i].delete();
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 4'hF; req_we = 4'hF; req_addr = '1; req_wdata = '1;
        #2 rst = 1'b1;
        #2;
        checks++;
        if ({gnt, rvalid} !== 8'h00) begin errors++; $display("FAIL reset_gnt_rvalid got %b %b required 0 0", gnt, rvalid); end
        checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b001) begin errors++; $display("FAIL reset_ctrl got cs/we/oe %b required 001", {ram_cs, ram_we, ram_oe}); end
        checks++;
        if ({ram_addr, ram_wdata, rdata} !== 24'h0) begin errors++; $display("FAIL reset_data got %h %h %h required 0", ram_addr, ram_wdata, rdata); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bq[1].push_back(beat_t'{we: 1'b1, addr: 8'h10, data: 8'h5A});
        bq[1].push_back(beat_t'{we: 1'b0, addr: 8'h10, data: 8'h00});
        run(40, 0);
        checks++;
        if (tr_gnt[0] !== 4'b0000 || tr_gnt[1] !== 4'b0010) begin errors++; $display("FAIL single_wr_gnt got c0 %b c1 %b required 0000 0010", tr_gnt[0], tr_gnt[1]); end
        checks++;
        if ({tr_cs[2], tr_we[2], tr_oe[2]} !== 3'b110) begin errors++; $display("FAIL single_wr_cmd got %b required 110", {tr_cs[2], tr_we[2], tr_oe[2]}); end
        checks++;
        if ({tr_cs[3], tr_oe[3], tr_gnt[3]} !== 6'b010000) begin errors++; $display("FAIL single_turn got cs %b oe %b gnt %b", tr_cs[3], tr_oe[3], tr_gnt[3]); end
        checks++;
        if (tr_gnt[4] !== 4'b0010 || {tr_cs[5], tr_we[5], tr_oe[5]} !== 3'b101) begin errors++; $display("FAIL single_rd_cmd got gnt %b cmd %b", tr_gnt[4], {tr_cs[5], tr_we[5], tr_oe[5]}); end
        checks++;
        if (tr_rv[6] !== 4'b0010 || tr_rd[6] !== 8'h5A) begin errors++; $display("FAIL single_rdata got %b %h required 0010 5a", tr_rv[6], tr_rd[6]); end
    endtask

    task automatic test_burst();
        int bad = 0;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            bq[0].push_back(beat_t'{we: 1'b0, addr: 8'(k), data: 8'h00});
            bq[2].push_back(beat_t'{we: 1'b0, addr: 8'(100 + k), data: 8'h00});
        end
        run(400, 0);
        checks++;
        if (g_id.size() != 80) bad++;
        else for (int k = 0; k < 48; k++) if (g_id[k] != (((k / 16) % 2 == 1) ? 2 : 0)) bad++;
        if (bad != 0) begin errors++; $display("FAIL burst_order got %0d grants with %0d wrong owners", g_id.size(), bad); end
        bad = 0;
        for (int k = 1; k < g_id.size(); k++)
            if (g_cyc[k] - g_cyc[k-1] != ((g_id[k] == g_id[k-1]) ? 1 : 3)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL burst_gaps got %0d irregular gaps required 0", bad); end
    endtask

    task automatic test_long();
        do_reset();
        for (int k = 0; k < 40; k++) bq[3].push_back(beat_t'{we: 1'b0, addr: 8'(200 + k), data: 8'h00});
        run(200, 0);
        checks++;
        if (g_id.size() != 40 || g_cyc[0] != 1 || g_cyc[g_id.size()-1] != 40)
            begin errors++; $display("FAIL long_stream got %0d grants first %0d last %0d required 40 1 40", g_id.size(), g_cyc[0], g_cyc[g_id.size()-1]); end
    endtask

    task automatic test_alternate();
        int bad = 0;
        do_reset();
        bq[1].push_back(beat_t'{we: 1'b1, addr: 8'h20, data: 8'h11});
        bq[1].push_back(beat_t'{we: 1'b0, addr: 8'h20, data: 8'h00});
        bq[1].push_back(beat_t'{we: 1'b1, addr: 8'h21, data: 8'h22});
        bq[1].push_back(beat_t'{we: 1'b0, addr: 8'h21, data: 8'h00});
        run(60, 0);
        for (int c = 0; c <= 12; c++) if (tr_cs[c] !== (c == 2 || c == 5 || c == 8 || c == 11)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL alt_cs_pattern got %0d wrong cycles required 0", bad); end
        bad = 0;
        for (int c = 3; c <= 9; c += 3) if ({tr_cs[c], tr_oe[c], tr_gnt[c]} !== 6'b010000) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL alt_turn got %0d bad turnaround cycles required 0", bad); end
        bad = 0;
        for (int c = 0; c < 12; c++) if (tr_cs[c] && !tr_we[c] && tr_oe[c+1] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL alt_contention got %0d cycles required 0", bad); end
    endtask

    task automatic test_rr();
        int exp_ids[4] = '{2, 3, 0, 1};
        int bad = 0;
        do_reset();
        bq[1].push_back(beat_t'{we: 1'b0, addr: 8'h30, data: 8'h00});
        run(20, 0);
        for (int i = 0; i < 4; i++) bq[i].push_back(beat_t'{we: 1'b0, addr: 8'(8'h40 + i), data: 8'h00});
        run(60, 0);
        if (g_id.size() != 4) bad++;
        else for (int k = 0; k < 4; k++) if (g_id[k] != exp_ids[k] || (k > 0 && g_cyc[k] - g_cyc[k-1] != 3)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rr_order got %0d grants with %0d wrong required order 2 3 0 1", g_id.size(), bad); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bq[2].push_back(beat_t'{we: 1'b0, addr: 8'h05, data: 8'h00});
        run(20, 0);
        for (int k = 6; k < 10; k++) bq[2].push_back(beat_t'{we: 1'b0, addr: 8'(k), data: 8'h00});
        run(40, 2);
        rst = 1'b1;
        #1;
        checks++;
        if ({rvalid, gnt, ram_cs, ram_oe, busy} !== 11'b00000000010) begin errors++; $display("FAIL midrst_immediate got rvalid %b gnt %b cs %b oe %b busy %b", rvalid, gnt, ram_cs, ram_oe, busy); end
        sb.delete();
        for (int i = 0; i < 4; i++) bq[i].delete();
        @(negedge clk);
        checks++;
        if (rvalid !== 4'h0 || ram_cs !== 1'b0) begin errors++; $display("FAIL midrst_hold got rvalid %b cs %b required 0 0", rvalid, ram_cs); end
        do_reset();
        bq[3].push_back(beat_t'{we: 1'b0, addr: 8'h50, data: 8'h00});
        bq[0].push_back(beat_t'{we: 1'b0, addr: 8'h51, data: 8'h00});
        run(60, 0);
        checks++;
        if (g_id.size() != 2 || g_id[0] != 0) begin errors++; $display("FAIL midrst_restart got first owner %0d of %0d grants required 0", g_id[0], g_id.size()); end
    endtask

    initial begin
        rst = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_single();
        test_burst();
        test_long();
        test_alternate();
        test_rr();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
